// File: rtl/if_fetch_stage.sv
// if_fetch_stage: single-issue instruction fetch with a one-entry skid buffer.
// State is clocked on the falling edge of clk.
module if_fetch_stage #(
    parameter int PC_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  I_stall,
    input  logic                  I_flush,
    input  logic [PC_WIDTH-1:0]   I_redirectPC,
    output logic                  O_imemReq,
    output logic [PC_WIDTH-1:0]   O_imemAddr,
    input  logic                  I_imemReady,
    input  logic [DATA_WIDTH-1:0] I_imemData,
    output logic [DATA_WIDTH-1:0] O_instr,
    output logic [PC_WIDTH-1:0]   O_pc,
    output logic [PC_WIDTH-1:0]   O_nextPC,
    output logic                  O_valid
);
    typedef enum logic {FETCH, HOLD} state_t;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
    localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);

    state_t state, stateNext;
    logic [PC_WIDTH-1:0] pc, pcNext, pcOutNext, nextPcNext, skidPc, skidPcNext;
    logic [DATA_WIDTH-1:0] instrNext, skidInstr, skidInstrNext;
    logic validNext;

    assign O_imemReq = rst_n && state == FETCH;
    assign O_imemAddr = pc;

    always_comb begin
        stateNext = state;
        pcNext = pc;
        instrNext = O_instr;
        pcOutNext = O_pc;
        nextPcNext = O_nextPC;
        validNext = O_valid;
        skidInstrNext = skidInstr;
        skidPcNext = skidPc;
        if (I_flush) begin
            stateNext = FETCH;
            pcNext = I_redirectPC & ~PC_WIDTH'(3);
            instrNext = NOP;
            validNext = 1'b0;
            skidInstrNext = '0;
            skidPcNext = '0;
        end else if (state == HOLD) begin
            if (!I_stall) begin
                stateNext = FETCH;
                instrNext = skidInstr;
                pcOutNext = skidPc;
                nextPcNext = skidPc + FOUR;
                validNext = 1'b1;
            end
        end else if (I_imemReady) begin
            pcNext = pc + FOUR;
            if (!I_stall || !O_valid) begin
                instrNext = I_imemData;
                pcOutNext = pc;
                nextPcNext = pc + FOUR;
                validNext = 1'b1;
            end else begin
                // decode is full: park the word so it is not lost
                stateNext = HOLD;
                skidInstrNext = I_imemData;
                skidPcNext = pc;
            end
        end else if (!I_stall) begin
            instrNext = NOP;
            validNext = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            O_instr <= NOP;
            O_pc <= '0;
            O_nextPC <= '0;
            O_valid <= 1'b0;
            skidInstr <= '0;
            skidPc <= '0;
        end else begin
            state <= stateNext;
            pc <= pcNext;
            O_instr <= instrNext;
            O_pc <= pcOutNext;
            O_nextPC <= nextPcNext;
            O_valid <= validNext;
            skidInstr <= skidInstrNext;
            skidPc <= skidPcNext;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: vector table with expected IF/ID outputs after each falling edge.
// Instruction memory returns addr ^ K so instructions are distinguishable from addresses.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 0, rst_n = 1, stall = 0, flush = 0, ready = 0;
    logic [31:0] redir = '0;
    logic req, valid;
    logic [31:0] addr, data, instr, pc, nextPc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign data = addr ^ K;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .I_stall(stall), .I_flush(flush),
        .I_redirectPC(redir), .O_imemReq(req), .O_imemAddr(addr),
        .I_imemReady(ready), .I_imemData(data), .O_instr(instr),
        .O_pc(pc), .O_nextPC(nextPc), .O_valid(valid)
    );

    typedef struct {
        logic s, f, r;
        logic [31:0] rd;
        logic eReq;
        logic [31:0] eAddr;
        logic eValid;
        logic [31:0] ePc, eInstr, eNext;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic logic [31:0] ins(logic [31:0] a);
        return a ^ K;
    endfunction

    function automatic vec_t v(logic s, logic f, logic r, logic [31:0] rd, logic eReq,
                               logic [31:0] eAddr, logic eValid, logic [31:0] ePc,
                               logic [31:0] eInstr, logic [31:0] eNext);
        vec_t t;
        t.s = s; t.f = f; t.r = r; t.rd = rd;
        t.eReq = eReq; t.eAddr = eAddr; t.eValid = eValid;
        t.ePc = ePc; t.eInstr = eInstr; t.eNext = eNext;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(string tag, vec_t e);
        check({tag, " req"}, 32'(req), 32'(e.eReq));
        check({tag, " addr"}, addr, e.eAddr);
        check({tag, " valid"}, 32'(valid), 32'(e.eValid));
        check({tag, " pc"}, pc, e.ePc);
        check({tag, " instr"}, instr, e.eInstr);
        check({tag, " nextPC"}, nextPc, e.eNext);
    endtask

    initial begin
        vec_t e;
        // reset/start: 0,4,8,12 back to back
        vecs.push_back(v(0,0,1,0,           1,32'h4,1,32'h0,ins(0),32'h4));
        vecs.push_back(v(0,0,1,0,           1,32'h8,1,32'h4,ins(4),32'h8));
        vecs.push_back(v(0,0,1,0,           1,32'hC,1,32'h8,ins(8),32'hC));
        vecs.push_back(v(0,0,1,0,           1,32'h10,1,32'hC,ins(12),32'h10));
        // redirect to 8, memory not ready two cycles
        vecs.push_back(v(0,1,1,32'h8,       1,32'h8,0,32'hC,NOP,32'h10));
        vecs.push_back(v(0,0,0,0,           1,32'h8,0,32'hC,NOP,32'h10));
        vecs.push_back(v(0,0,0,0,           1,32'h8,0,32'hC,NOP,32'h10));
        vecs.push_back(v(0,0,1,0,           1,32'hC,1,32'h8,ins(8),32'hC));
        // O_pc=4 valid, then three stall cycles into HOLD
        vecs.push_back(v(0,1,0,32'h4,       1,32'h4,0,32'h8,NOP,32'hC));
        vecs.push_back(v(0,0,1,0,           1,32'h8,1,32'h4,ins(4),32'h8));
        vecs.push_back(v(1,0,1,0,           0,32'hC,1,32'h4,ins(4),32'h8));
        vecs.push_back(v(1,0,1,0,           0,32'hC,1,32'h4,ins(4),32'h8));
        vecs.push_back(v(1,0,0,0,           0,32'hC,1,32'h4,ins(4),32'h8));
        vecs.push_back(v(0,0,1,0,           1,32'hC,1,32'h8,ins(8),32'hC));
        vecs.push_back(v(0,0,1,0,           1,32'h10,1,32'hC,ins(12),32'h10));
        // HOLD with 16 buffered, flush to 0x103
        vecs.push_back(v(1,0,1,0,           0,32'h14,1,32'hC,ins(12),32'h10));
        vecs.push_back(v(1,1,0,32'h103,     1,32'h100,0,32'hC,NOP,32'h10));
        vecs.push_back(v(0,0,1,0,           1,32'h104,1,32'h100,ins(32'h100),32'h104));
        // flush + stall + ready together, then stalled fetch into an empty IF/ID
        vecs.push_back(v(1,1,1,32'h200,     1,32'h200,0,32'h100,NOP,32'h104));
        vecs.push_back(v(1,0,1,0,           1,32'h204,1,32'h200,ins(32'h200),32'h204));
        // wrap at top of address space
        vecs.push_back(v(0,1,1,32'hFFFFFFFC,1,32'hFFFFFFFC,0,32'h200,NOP,32'h204));
        vecs.push_back(v(0,0,1,0,           1,32'h0,1,32'hFFFFFFFC,ins(32'hFFFFFFFC),32'h0));
        vecs.push_back(v(0,0,1,0,           1,32'h4,1,32'h0,ins(0),32'h4));
        vecs.push_back(v(1,0,0,0,           1,32'h4,1,32'h0,ins(0),32'h4));
        vecs.push_back(v(1,0,1,0,           0,32'h8,1,32'h0,ins(0),32'h4));

        #1 rst_n = 0;
        #1 checkAll("reset", v(0,0,0,0, 0,32'h0,0,32'h0,NOP,32'h0));
        @(posedge clk);
        rst_n = 1;
        #1;
        check("release req", 32'(req), 32'd1);
        check("release addr", addr, 32'h0);
        foreach (vecs[i]) begin
            @(posedge clk);
            stall = vecs[i].s; flush = vecs[i].f; ready = vecs[i].r; redir = vecs[i].rd;
            sb.push_back(vecs[i]);
            @(negedge clk);
            #2;
            e = sb.pop_front();
            checkAll($sformatf("v%0d", i), e);
        end
        // asynchronous reset while holding a buffered word
        @(posedge clk);
        rst_n = 0;
        #1 checkAll("async rst", v(0,0,0,0, 0,32'h0,0,32'h0,NOP,32'h0));
        @(negedge clk);
        @(posedge clk);
        rst_n = 1; stall = 0; flush = 0; ready = 1;
        sb.push_back(v(0,0,1,0, 1,32'h4,1,32'h0,ins(0),32'h4));
        @(negedge clk);
        #2;
        e = sb.pop_front();
        checkAll("post rst", e);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
